// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, state encoding and redirect helper for the pipeline
// stall/flush controller.
package pipe_ctrl_pkg;

    // Per-stage stall bit values
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Stall masks: bit 0 = PC ... bit 5 = WB; a stage stops together with every stage in front of it
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    // MEM-stage exception codes
    localparam logic [31:0] EXC_NONE = 32'h0000_0000;
    localparam logic [31:0] EXC_ERET = 32'h0000_000E;

    // Multi-cycle EX sequencer states
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_WAIT = 1'b1
    } mc_state_e;

    // ERET returns to the saved EPC; every other exception enters the common vector
    function automatic logic [31:0] redirect_pc(
        input logic [31:0] exc_code,
        input logic [31:0] epc,
        input logic [31:0] exc_vec
    );
        logic [31:0] pc;
        if (exc_code == EXC_ERET) begin
            pc = epc;
        end else begin
            pc = exc_vec;
        end
        return pc;
    endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating stall-cycle counter with synchronous clear (clear beats increment).
module pipe_ctrl_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: merges stage stall
// requests into one stall vector, raises flush with a redirect PC on
// exceptions, sequences multi-cycle EX ops with a timeout and counts stall cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VEC    = 32'h0000_0020,
    parameter int          MC_TIMEOUT = 64,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             mc_start,
    input  logic             mc_done,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    input  logic             perf_clr,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             mc_abort,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int             MCW   = $clog2(MC_TIMEOUT + 1);
    localparam logic [MCW-1:0] MC_TO = MCW'(MC_TIMEOUT);

    mc_state_e      state_q;
    logic [MCW-1:0] cnt_q;
    logic           mc_abort_q;
    logic           mc_timeout_q;

    logic           flush_req_s;
    logic           mc_hold_s;
    logic           ex_req_s;
    logic [5:0]     stall_s;
    logic           flush_s;
    logic [31:0]    new_pc_s;

    assign flush_req_s = (excepttype_i != EXC_NONE);

    // Multi-cycle hold: the mc_start cycle already stops EX (unless the op completes at once);
    // in MC_WAIT the hold drops on mc_done and on the final timeout cycle, so at most
    // MC_TIMEOUT cycles are held in total.
    always_comb begin
        mc_hold_s = 1'b0;
        case (state_q)
            ST_RUN:     mc_hold_s = mc_start && !mc_done;
            ST_MC_WAIT: mc_hold_s = !mc_done && (cnt_q != MC_TO);
            default:    mc_hold_s = 1'b0;
        endcase
    end

    assign ex_req_s = stallreq_ex || mc_hold_s;

    // Priority mux for stall/flush/redirect; all forced low while reset is held
    always_comb begin
        stall_s  = STALL_NONE;
        flush_s  = 1'b0;
        new_pc_s = 32'h0000_0000;
        if (!rst) begin
            stall_s  = STALL_NONE;
            flush_s  = 1'b0;
            new_pc_s = 32'h0000_0000;
        end else if (flush_req_s) begin
            stall_s  = STALL_NONE;
            flush_s  = 1'b1;
            new_pc_s = redirect_pc(excepttype_i, cp0_epc_i, EXC_VEC);
        end else if (stallreq_mem) begin
            stall_s = STALL_MEM;
        end else if (ex_req_s) begin
            stall_s = STALL_EX;
        end else if (stallreq_id) begin
            stall_s = STALL_ID;
        end else if (stallreq_if) begin
            stall_s = STALL_IF;
        end else begin
            stall_s = STALL_NONE;
        end
    end

    assign stall  = stall_s;
    assign flush  = flush_s;
    assign new_pc = new_pc_s;

    // Multi-cycle sequencer: state, wait counter and registered abort/timeout pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            cnt_q        <= {MCW{1'b0}};
            mc_abort_q   <= 1'b0;
            mc_timeout_q <= 1'b0;
        end else begin
            mc_abort_q   <= 1'b0;
            mc_timeout_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (mc_start && !mc_done && !flush_req_s) begin
                        state_q <= ST_MC_WAIT;
                        cnt_q   <= {{(MCW-1){1'b0}}, 1'b1};
                    end else begin
                        state_q <= ST_RUN;
                        cnt_q   <= {MCW{1'b0}};
                    end
                end
                ST_MC_WAIT: begin
                    if (flush_req_s) begin
                        state_q    <= ST_RUN;
                        cnt_q      <= {MCW{1'b0}};
                        mc_abort_q <= 1'b1;
                    end else if (mc_done) begin
                        state_q <= ST_RUN;
                        cnt_q   <= {MCW{1'b0}};
                    end else if (cnt_q == MC_TO) begin
                        state_q      <= ST_RUN;
                        cnt_q        <= {MCW{1'b0}};
                        mc_timeout_q <= 1'b1;
                    end else begin
                        state_q <= ST_MC_WAIT;
                        cnt_q   <= cnt_q + {{(MCW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    cnt_q   <= {MCW{1'b0}};
                end
            endcase
        end
    end

    assign mc_abort   = mc_abort_q;
    assign mc_timeout = mc_timeout_q;

    pipe_ctrl_perf #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk   (clk),
        .rst   (rst),
        .clr_i (perf_clr),
        .en_i  (stall_s[0] && !flush_s),
        .cnt_o (stall_cycles)
    );

endmodule
